// File: rtl/hilo_unit_pkg.sv
// rtl/hilo_unit_pkg.sv - shared state encodings and counter width for the HI/LO unit
package hilo_unit_pkg;

  localparam int HILO_CNT_W = 4;

  typedef enum logic {
    HILO_ST_IDLE = 1'b0,
    HILO_ST_WAIT = 1'b1
  } hilo_state_t;

  // Wait cycles remaining after the issue cycle; LAT is limited to 1..15.
  function automatic logic [HILO_CNT_W-1:0] lat_to_cnt(input int lat);
    return HILO_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - HI and LO registers with independent write enables
// Optional combinational write-through forwarding under HILO_FWD_EN.
module hilo_regs
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_hi_i,
  input  logic        we_lo_i,
  input  logic [31:0] hi_d_i,
  input  logic [31:0] lo_d_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (we_hi_i) r_hi <= hi_d_i;
      if (we_lo_i) r_lo <= lo_d_i;
    end
  end

`ifdef HILO_FWD_EN
  assign hi_o = we_hi_i ? hi_d_i : r_hi;
  assign lo_o = we_lo_i ? lo_d_i : r_lo;
`else
  assign hi_o = r_hi;
  assign lo_o = r_lo;
`endif

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - multi-cycle HI/LO unit: stalls for MUL_LAT/DIV_LAT cycles, then commits the ALU result
// Optional HILO_FWD_EN forwards written values onto hi_o/lo_o in the write cycle.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start_i,
  input  logic        md_is_div_i,
  input  logic [63:0] aluout_i,
  input  logic        flush_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o
);

  hilo_state_t           r_state;
  hilo_state_t           w_state_nxt;
  logic [HILO_CNT_W-1:0] r_cnt;
  logic [HILO_CNT_W-1:0] w_cnt_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_we_hi;
  logic                  w_we_lo;
  logic [31:0]           w_hi_d;
  logic [31:0]           w_lo_d;
  logic                  w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HILO_ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_we_hi     = 1'b0;
    w_we_lo     = 1'b0;
    w_hi_d      = wdata_i;
    w_lo_d      = wdata_i;
    w_busy      = 1'b0;
    case (r_state)
      HILO_ST_IDLE: begin
        w_busy = md_start_i;
        if (md_start_i && !flush_i) begin
          w_cnt_nxt   = md_is_div_i ? lat_to_cnt(DIV_LAT) : lat_to_cnt(MUL_LAT);
          w_state_nxt = HILO_ST_WAIT;
        end else if (!md_start_i) begin
          w_we_hi = mthi_i;
          w_we_lo = mtlo_i;
        end
      end
      HILO_ST_WAIT: begin
        w_busy = (r_cnt != '0);
        // Flush outranks the commit, so an abort in the final cycle writes nothing.
        if (flush_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = HILO_ST_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_we_hi     = 1'b1;
          w_we_lo     = 1'b1;
          w_hi_d      = aluout_i[63:32];
          w_lo_d      = aluout_i[31:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = HILO_ST_IDLE;
        end
      end
      default: w_state_nxt = HILO_ST_IDLE;
    endcase
  end

  hilo_regs u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_hi_i (w_we_hi),
    .we_lo_i (w_we_lo),
    .hi_d_i  (w_hi_d),
    .lo_d_i  (w_lo_d),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  assign busy_o = w_busy;
  assign done_o = r_done;

endmodule
